sp_ram_arbiter: RTL

- Two-master request/grant arbiter placed directly upstream of the single-port RAM wrapper.
- Port 0 is normally the core data port; port 1 is normally the AXI/debug memory interface.
- Arbitrates round-robin, drives one RAM access per cycle, and returns the 1-cycle-latency read data to the granted master.
- Each port gets a response-valid pulse and a read-data value that holds between responses.

---
 rtl/sp_ram_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sp_ram_arbiter.sv
// Purpose     : two-master round-robin arbiter in front of a single-port RAM wrapper.
// Latency     : grant is combinational with request; rvalid/rdata arrive one cycle after grant.
// Backpressure: a master holds req and its fields until gnt; under contention the loser waits one cycle.
//
// Ports
//   clk, rst_i                 single clock, synchronous active-high reset
//   pN_req_i / pN_gnt_o        per-master request and same-cycle grant (N = 0, 1)
//   pN_addr_i, pN_we_i,        per-master access fields (byte address, write enable,
//   pN_be_i, pN_wdata_i        byte enables, write data)
//   pN_rvalid_o, pN_rdata_o    per-master response pulse and held read data
//   ram_en_o .. ram_be_o       one RAM access per cycle, muxed from the granted master
//   ram_rdata_i                RAM read data, valid one cycle after an enabled read
module sp_ram_arbiter #(
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_i,

    input  logic                    p0_req_i,
    input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
    input  logic                    p0_we_i,
    input  logic [DATA_WIDTH/8-1:0] p0_be_i,
    input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
    output logic                    p0_gnt_o,
    output logic                    p0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p0_rdata_o,

    input  logic                    p1_req_i,
    input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
    input  logic                    p1_we_i,
    input  logic [DATA_WIDTH/8-1:0] p1_be_i,
    input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
    output logic                    p1_gnt_o,
    output logic                    p1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   p1_rdata_o,

    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // One master's access fields bundled so the RAM mux is a single select.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  we;
        logic [BE_WIDTH-1:0]   be;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    req_t                  w_p0_req;
    req_t                  w_p1_req;
    req_t                  w_ram_req;
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_any_gnt;

    // r_last holds the index of the most recently granted port.
    logic                  r_last;
    logic [1:0]            r_pend;
    logic [DATA_WIDTH-1:0] r_hold0;
    logic [DATA_WIDTH-1:0] r_hold1;

    assign w_p0_req = {p0_addr_i, p0_we_i, p0_be_i, p0_wdata_i};
    assign w_p1_req = {p1_addr_i, p1_we_i, p1_be_i, p1_wdata_i};

    // A lone requester always wins; on a conflict the port that did not win
    // last time is served. Reset leaves r_last=1 so port 0 wins the first tie.
    assign w_gnt0    = p0_req_i & (~p1_req_i | r_last);
    assign w_gnt1    = p1_req_i & (~p0_req_i | ~r_last);
    assign w_any_gnt = w_gnt0 | w_gnt1;

    // Idle cycles present port 0's address/data so the RAM inputs do not
    // toggle needlessly; only we/be are forced low to keep the access harmless.
    always_comb begin
        w_ram_req = w_gnt1 ? w_p1_req : w_p0_req;
        if (!w_any_gnt) begin
            w_ram_req.we = 1'b0;
            w_ram_req.be = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_last  <= 1'b1;
            r_pend  <= 2'b00;
            r_hold0 <= '0;
            r_hold1 <= '0;
        end else begin
            if (w_any_gnt) begin
                r_last <= w_gnt1;
            end
            r_pend <= {w_gnt1, w_gnt0};
            // Capture the RAM output on the response cycle so rdata stays
            // stable until this port's next response.
            if (r_pend[0]) begin
                r_hold0 <= ram_rdata_i;
            end
            if (r_pend[1]) begin
                r_hold1 <= ram_rdata_i;
            end
        end
    end

    assign p0_gnt_o    = w_gnt0;
    assign p1_gnt_o    = w_gnt1;

    assign ram_en_o    = w_any_gnt;
    assign ram_addr_o  = w_ram_req.addr;
    assign ram_we_o    = w_ram_req.we;
    assign ram_be_o    = w_ram_req.be;
    assign ram_wdata_o = w_ram_req.wdata;

    assign p0_rvalid_o = r_pend[0];
    assign p1_rvalid_o = r_pend[1];
    assign p0_rdata_o  = r_pend[0] ? ram_rdata_i : r_hold0;
    assign p1_rdata_o  = r_pend[1] ? ram_rdata_i : r_hold1;

    // Structural invariants of the arbiter.
    a_gnt_onehot : assert property (@(posedge clk) !(w_gnt0 && w_gnt1));
    a_p0_rvalid  : assert property (@(posedge clk) disable iff (rst_i) w_gnt0 |=> p0_rvalid_o);
    a_p1_rvalid  : assert property (@(posedge clk) disable iff (rst_i) w_gnt1 |=> p1_rvalid_o);

endmodule
